// File: rtl/avalon_st_adt_pkg.sv
// Shared constants and parameter-legality helpers for the Avalon-ST timing FIFO.
package avalon_st_adt_pkg;

  localparam int DROP_CNT_W = 16;

  // Storage depth must be a power of two so the pointers wrap for free.
  function automatic bit depth_legal(input int depth);
    return (depth >= 2) && (depth <= 64) && ((depth & (depth - 1)) == 0);
  endfunction

  // Only zero- and one-cycle downstream ready latencies are supported.
  function automatic bit ready_latency_legal(input int rl);
    return (rl == 0) || (rl == 1);
  endfunction

  function automatic bit data_w_legal(input int w);
    return (w >= 1) && (w <= 512);
  endfunction

endpackage

// File: rtl/avalon_st_adt_ram_fifo.sv
// Circular buffer with wrapping pointers, fill counter and a registered,
// write-first head entry so the output never has a path from wr_data.
module avalon_st_adt_ram_fifo
  import avalon_st_adt_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          wr_data,
  output logic [DATA_W-1:0]          head_data,
  output logic [$clog2(DEPTH):0]     fill_level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  fill_q, fill_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  // Next pointers, fill count and head entry (bypassing a same-cycle write).
  // NOTE: every always_comb output gets a default first, otherwise a missed branch infers a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    head_d   = head_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   fill_d = fill_q + 1'b1;
      2'b01:   fill_d = fill_q - 1'b1;
      default: fill_d = fill_q;
    endcase
    // The head only reloads while something is stored; when empty it holds.
    if (fill_d != '0) begin
      if (push && (wr_ptr_q == rd_ptr_d)) head_d = wr_data;
      else                                head_d = mem_q[rd_ptr_d];
    end
  end

  // Control state and head register, cleared asynchronously.
  // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      head_q   <= head_d;
    end
  end

  // Storage array write port.
  // NOTE: the storage array has no reset; the pointers and fill count alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign head_data  = head_q;
  assign fill_level = fill_q;

endmodule

// File: rtl/avalon_st_timing_fifo_adt.sv
// Avalon-ST timing FIFO: ready-less upstream, ready-latency 0/1 downstream,
// with sticky overflow flag and saturating drop counter.
module avalon_st_timing_fifo_adt
  import avalon_st_adt_pkg::*;
#(
  parameter int unsigned DATA_W            = 8,
  parameter int unsigned DEPTH             = 4,
  parameter int unsigned OUT_READY_LATENCY = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     fill_level,
  output logic                       overflow,
  output logic [DROP_CNT_W-1:0]      drop_count,
  input  logic                       clr_overflow
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  if (!depth_legal(DEPTH)) begin : g_bad_depth
    $error("avalon_st_timing_fifo_adt: DEPTH=%0d must be a power of two in 2..64", DEPTH);
  end
  if (!ready_latency_legal(OUT_READY_LATENCY)) begin : g_bad_rl
    $error("avalon_st_timing_fifo_adt: OUT_READY_LATENCY=%0d must be 0 or 1", OUT_READY_LATENCY);
  end
  if (!data_w_legal(DATA_W)) begin : g_bad_w
    $error("avalon_st_timing_fifo_adt: DATA_W=%0d must be in 1..512", DATA_W);
  end

  logic [CNT_W-1:0]      fill;
  logic [DATA_W-1:0]     head;
  logic                  pop;
  logic                  push;
  logic                  drop;
  logic                  ready_d_q, ready_d_d;
  logic                  overflow_q, overflow_d;
  logic [DROP_CNT_W-1:0] drop_count_q, drop_count_d;

  avalon_st_adt_ram_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .wr_data    (in_data),
    .head_data  (head),
    .fill_level (fill)
  );

  // Downstream handshake, push acceptance and overflow accounting.
  always_comb begin
    if (OUT_READY_LATENCY == 0) begin
      out_valid = (fill != '0);
      pop       = out_valid && out_ready;
      ready_d_d = 1'b0;
    end else begin
      // With ready latency 1 the sink may only be offered data one cycle after ready.
      out_valid = ready_d_q && (fill != '0);
      pop       = out_valid;
      ready_d_d = out_ready;
    end
    // A full buffer still takes a beat when the head leaves in the same cycle.
    push = in_valid && ((fill < CNT_W'(DEPTH)) || pop);
    drop = in_valid && !push;

    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;
    if (clr_overflow) begin
      overflow_d   = 1'b0;
      drop_count_d = '0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_count_q != '1) drop_count_d = drop_count_q + 1'b1;
    end
  end

  // Ready delay line and overflow state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_d_q    <= 1'b0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      ready_d_q    <= ready_d_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign out_data   = head;
  assign fill_level = fill;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

`ifndef SYNTHESIS
  // Announce every discarded beat in simulation.
  always_ff @(posedge clk) begin
    if (!reset && drop) $info("%m: beat dropped (drop_count=%0d)", drop_count_q);
  end
`endif

endmodule

// File: tb/tb_avalon_st_timing_fifo_adt.sv
// Scoreboard bench: one DUT per ready latency, shared stimulus, queue-based model.
module tb_avalon_st_timing_fifo_adt;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_ready;
  logic          clr_overflow;

  logic          ov  [2];
  logic [DW-1:0] od  [2];
  logic [CW-1:0] fl  [2];
  logic          ovf [2];
  logic [15:0]   dc  [2];

  int n_checks = 0;
  int n_pass   = 0;

  // Model state per instance (index = ready latency).
  logic [DW-1:0] exp_q [2][$];
  bit            rdd   [2];
  bit            m_ovf [2];
  int            m_drop[2];
  bit            m_pop [2];

  always #5 clk = ~clk;

  avalon_st_timing_fifo_adt #(.DATA_W(DW), .DEPTH(DEPTH), .OUT_READY_LATENCY(0)) u_rl0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov[0]), .out_data(od[0]), .out_ready(out_ready),
    .fill_level(fl[0]), .overflow(ovf[0]), .drop_count(dc[0]), .clr_overflow(clr_overflow));

  avalon_st_timing_fifo_adt #(.DATA_W(DW), .DEPTH(DEPTH), .OUT_READY_LATENCY(1)) u_rl1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov[1]), .out_data(od[1]), .out_ready(out_ready),
    .fill_level(fl[1]), .overflow(ovf[1]), .drop_count(dc[1]), .clr_overflow(clr_overflow));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
  endtask

  // Monitor: compare DUT outputs with the model, pop expected beats on transfer.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_pop[i] = 1'b0;
      end else begin
        bit ev;
        ev = (exp_q[i].size() != 0) && (i == 0 || rdd[i]);
        check($sformatf("out_valid_rl%0d", i), 32'(ov[i]), 32'(ev));
        check($sformatf("fill_level_rl%0d", i), 32'(fl[i]), 32'(exp_q[i].size()));
        check($sformatf("overflow_rl%0d", i), 32'(ovf[i]), 32'(m_ovf[i]));
        check($sformatf("drop_count_rl%0d", i), 32'(dc[i]), 32'(m_drop[i]));
        m_pop[i] = ev && (i == 1 || out_ready);
        if (m_pop[i]) begin
          logic [DW-1:0] e;
          e = exp_q[i].pop_front();
          check($sformatf("out_data_rl%0d", i), 32'(od[i]), 32'(e));
        end
      end
    end
  end

  // Predictor: apply this cycle's stimulus to the model once the monitor has popped.
  always @(negedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        exp_q[i].delete();
        rdd[i]    = 1'b0;
        m_ovf[i]  = 1'b0;
        m_drop[i] = 0;
        m_pop[i]  = 1'b0;
      end else begin
        int  pre;
        bit  dropped;
        pre     = exp_q[i].size() + (m_pop[i] ? 1 : 0);
        dropped = 1'b0;
        if (in_valid) begin
          if (pre < DEPTH || m_pop[i]) exp_q[i].push_back(in_data);
          else dropped = 1'b1;
        end
        if (clr_overflow) begin
          m_ovf[i]  = 1'b0;
          m_drop[i] = 0;
        end else if (dropped) begin
          m_ovf[i] = 1'b1;
          if (m_drop[i] < 16'hFFFF) m_drop[i]++;
        end
        rdd[i] = out_ready;
      end
    end
  end

  task automatic drive(input bit v, input logic [DW-1:0] d, input bit r, input bit c);
    in_valid     = v;
    in_data      = d;
    out_ready    = r;
    clr_overflow = c;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 6; k++) drive(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    reset = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clr_overflow = 1'b0;
    #1 reset = 1'b1;
    #2;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_out_valid_rl%0d", i), 32'(ov[i]), 0);
      check($sformatf("rst_fill_rl%0d", i), 32'(fl[i]), 0);
      check($sformatf("rst_out_data_rl%0d", i), 32'(od[i]), 0);
      check($sformatf("rst_drop_count_rl%0d", i), 32'(dc[i]), 0);
    end
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    // Steady stream 0x00..0x09 with the sink always ready.
    for (int k = 0; k < 10; k++) drive(1'b1, DW'(k), 1'b1, 1'b0);
    check("steady_overflow", 32'(ovf[0]), 0);
    drain();

    // Fill and overflow: 0x14, 0x15 are dropped.
    for (int k = 0; k < 6; k++) drive(1'b1, DW'(8'h10 + k), 1'b0, 1'b0);
    check("full_fill", 32'(fl[0]), 4);
    check("full_overflow", 32'(ovf[0]), 1);
    check("full_drop_count", 32'(dc[0]), 2);
    drain();
    check("drained_fill", 32'(fl[0]), 0);
    drive(1'b0, '0, 1'b0, 1'b1);

    // Push and pop while full: no drop, head advances.
    for (int k = 0; k < 4; k++) drive(1'b1, DW'(8'h20 + k), 1'b0, 1'b0);
    drive(1'b1, 8'h24, 1'b1, 1'b0);
    check("pushpop_fill", 32'(fl[0]), 4);
    check("pushpop_drop_count", 32'(dc[0]), 0);
    check("pushpop_head", 32'(od[0]), 32'h21);
    drain();
    drive(1'b0, '0, 1'b0, 1'b1);

    // Ready latency 1: a single-cycle ready pulse releases exactly one beat.
    for (int k = 0; k < 3; k++) drive(1'b1, DW'(8'h30 + k), 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    check("rl1_valid_after_pulse", 32'(ov[1]), 1);
    check("rl1_data_after_pulse", 32'(od[1]), 32'h30);
    drive(1'b0, '0, 1'b0, 1'b0);
    check("rl1_fill_after_pulse", 32'(fl[1]), 2);
    check("rl1_valid_after_beat", 32'(ov[1]), 0);
    drain();
    drive(1'b0, '0, 1'b0, 1'b1);

    // Clear takes priority over a same-cycle drop.
    for (int k = 0; k < 9; k++) drive(1'b1, DW'(8'h40 + k), 1'b0, 1'b0);
    check("pre_clear_drop_count", 32'(dc[0]), 5);
    drive(1'b1, 8'h4A, 1'b0, 1'b1);
    check("clear_overflow", 32'(ovf[0]), 0);
    check("clear_drop_count", 32'(dc[0]), 0);
    check("clear_keeps_data", 32'(fl[0]), 4);
    drain();

    // Reset mid-stream with three beats buffered.
    for (int k = 0; k < 3; k++) drive(1'b1, DW'(8'h50 + k), 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("midrst_out_valid_rl%0d", i), 32'(ov[i]), 0);
      check($sformatf("midrst_fill_rl%0d", i), 32'(fl[i]), 0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    drive(1'b1, 8'h55, 1'b1, 1'b0);
    check("post_rst_valid", 32'(ov[0]), 1);
    check("post_rst_data", 32'(od[0]), 32'h55);
    drain();

    // Randomized traffic.
    for (int k = 0; k < 400; k++)
      drive($urandom_range(0, 2) != 0, DW'($urandom), $urandom_range(0, 3) != 0,
            $urandom_range(0, 19) == 0);
    drain();
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
